mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
// Two-requester (CPU, debug/loader) arbiter in front of a single-port
// memory with a fixed read latency of MEM_LAT cycles.
//
// Ports
//   CLK, Reset           clock, synchronous active-high reset
//   cpu_req/we/addr/wdata  CPU request; req held until cpu_ack
//   cpu_ack, cpu_rdata     one-cycle completion pulse, read data (held)
//   dbg_*                  same as cpu_* for the debug/loader requester
//   mem_en/we/addr/wdata   memory strobe and latched access fields
//   mem_rdata              memory data, valid MEM_LAT cycles after mem_en
//   cpu_stall              cpu_req & ~cpu_ack
//   busy                   high while an access is in flight
module mem_arbiter #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_stall,
   output logic              busy
);

   generate
      if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_lat
         $error("mem_arbiter: MEM_LAT must be 1..3");
      end
   endgenerate

   localparam logic [1:0] LAT = 2'(MEM_LAT);

   typedef enum logic [1:0] {IDLE, CPU_ACC, DBG_ACC} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_last_dbg;   // 1: most recent grant went to DBG
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        r_cnt;        // cycles since the mem_en cycle
   logic              r_cpu_ack;
   logic              r_dbg_ack;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;

   logic              w_cpu_elig;
   logic              w_dbg_elig;
   logic              w_grant_cpu;
   logic              w_grant_dbg;
   logic              w_done;

   // A requester still holding req during its own ack cycle is not a
   // new request.
   assign w_cpu_elig = cpu_req & ~r_cpu_ack;
   assign w_dbg_elig = dbg_req & ~r_dbg_ack;

   always_comb begin
      w_next      = r_state;
      w_grant_cpu = 1'b0;
      w_grant_dbg = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            // The ack cycle is a turnaround cycle: no new grant issues
            // while either ack is pulsing.
            if (!(r_cpu_ack || r_dbg_ack)) begin
               if (w_cpu_elig && w_dbg_elig) begin
                  w_grant_cpu = r_last_dbg;
                  w_grant_dbg = ~r_last_dbg;
               end else begin
                  w_grant_cpu = w_cpu_elig;
                  w_grant_dbg = w_dbg_elig;
               end
            end
            if (w_grant_cpu)      w_next = CPU_ACC;
            else if (w_grant_dbg) w_next = DBG_ACC;
         end
         CPU_ACC, DBG_ACC: begin
            if (r_cnt == LAT) begin
               w_done = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_last_dbg  <= 1'b1;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_cpu_ack   <= 1'b0;
         r_dbg_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
      end else begin
         r_state   <= w_next;
         r_cpu_ack <= 1'b0;
         r_dbg_ack <= 1'b0;
         if (w_grant_cpu) begin
            r_we       <= cpu_we;
            r_addr     <= cpu_addr;
            r_wdata    <= cpu_wdata;
            r_last_dbg <= 1'b0;
            r_cnt      <= '0;
         end else if (w_grant_dbg) begin
            r_we       <= dbg_we;
            r_addr     <= dbg_addr;
            r_wdata    <= dbg_wdata;
            r_last_dbg <= 1'b1;
            r_cnt      <= '0;
         end else if (r_state != IDLE) begin
            r_cnt <= r_cnt + 2'd1;
         end
         // Completion: capture read data straight into the port register
         // so it appears together with the ack.
         if (w_done) begin
            if (r_state == CPU_ACC) begin
               r_cpu_ack <= 1'b1;
               if (!r_we) r_cpu_rdata <= mem_rdata;
            end else begin
               r_dbg_ack <= 1'b1;
               if (!r_we) r_dbg_rdata <= mem_rdata;
            end
         end
      end
   end

   assign busy      = (r_state != IDLE);
   assign mem_en    = busy && (r_cnt == 2'd0);
   assign mem_we    = mem_en & r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign cpu_ack   = r_cpu_ack;
   assign dbg_ack   = r_dbg_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign dbg_rdata = r_dbg_rdata;
   assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: a cycle table on a MEM_LAT=1 instance plus
// hand-written sequences for contention, reset mid-access and MEM_LAT=3.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;

   logic        cack1, dack1, en1, we1, stall1, busy1;
   logic [15:0] crd1, drd1, addr1, wd1;
   logic        cack3, dack3, en3, we3, stall3, busy3;
   logic [15:0] crd3, drd3, addr3, wd3;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1)) u_dut1 (
      .CLK(CLK), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cack1), .cpu_rdata(crd1),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dack1), .dbg_rdata(drd1),
      .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
      .mem_rdata(mem_rdata), .cpu_stall(stall1), .busy(busy1));

   mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(3)) u_dut3 (
      .CLK(CLK), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cack3), .cpu_rdata(crd3),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dack3), .dbg_rdata(drd3),
      .mem_en(en3), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wd3),
      .mem_rdata(mem_rdata), .cpu_stall(stall3), .busy(busy3));

   typedef struct {
      logic rst, creq, cwe; logic [15:0] caddr, cwd;
      logic dreq, dwe;      logic [15:0] daddr, dwd, mrd;
      logic chk, en, we;    logic [15:0] addr, wd;
      logic cack;           logic [15:0] crd;
      logic dack;           logic [15:0] drd;
      logic stall, busy;
   } vec_t;

   localparam int NV = 22;
   vec_t tv [NV];

   function automatic vec_t mk(
      input logic rst, creq, cwe, input logic [15:0] caddr, cwd,
      input logic dreq, dwe, input logic [15:0] daddr, dwd, mrd,
      input logic chk, en, we, input logic [15:0] addr, wd,
      input logic cack, input logic [15:0] crd,
      input logic dack, input logic [15:0] drd,
      input logic stall, busy);
      vec_t v;
      v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
      v.chk = chk; v.en = en; v.we = we; v.addr = addr; v.wd = wd;
      v.cack = cack; v.crd = crd; v.dack = dack; v.drd = drd;
      v.stall = stall; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      mem_rdata = 0;
   endtask

   initial begin
      Reset = 1'b1;
      drive_idle();

      //          rst creq we caddr    cwd      dreq we daddr    dwd      mrd       chk en we addr     wd       cack crd      dack drd      stall busy
      tv[0]  = mk(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000,16'h0000, 0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000, 0,0);
      tv[1]  = mk(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000, 0,0);
      // CPU read 0x0010, memory returns 0xBEEF
      tv[2]  = mk(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000, 1,0);
      tv[3]  = mk(0, 1,0,16'hFFFF,16'h0000, 0,0,16'h0000,16'h0000,16'h0000, 1, 1,0,16'h0010,16'h0000, 0,16'h0000, 0,16'h0000, 1,1);
      tv[4]  = mk(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000,16'hBEEF, 1, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000, 1,1);
      tv[5]  = mk(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 1,16'hBEEF, 0,16'h0000, 0,0);
      tv[6]  = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'hBEEF, 0,16'h0000, 0,0);
      // DBG write 0x1234 to 0x00FF; CPU side carries junk with req low
      tv[7]  = mk(0, 0,1,16'hABCD,16'h5555, 1,1,16'h00FF,16'h1234,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'hBEEF, 0,16'h0000, 0,0);
      tv[8]  = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h00FF,16'h1234,16'h0000, 1, 1,1,16'h00FF,16'h1234, 0,16'hBEEF, 0,16'h0000, 0,1);
      tv[9]  = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h00FF,16'h1234,16'hDEAD, 1, 0,0,16'h0000,16'h0000, 0,16'hBEEF, 0,16'h0000, 0,1);
      tv[10] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h00FF,16'h1234,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'hBEEF, 1,16'h0000, 0,0);
      tv[11] = mk(0, 0,1,16'h7777,16'h9999, 0,0,16'h0000,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'hBEEF, 0,16'h0000, 0,0);
      // reset, then simultaneous CPU/DBG reads: CPU wins the first tie
      tv[12] = mk(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'hBEEF, 0,16'h0000, 0,0);
      tv[13] = mk(0, 1,0,16'h0020,16'h0000, 1,0,16'h0030,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000, 1,0);
      tv[14] = mk(0, 1,0,16'h0020,16'h0000, 1,0,16'h0030,16'h0000,16'h0000, 1, 1,0,16'h0020,16'h0000, 0,16'h0000, 0,16'h0000, 1,1);
      tv[15] = mk(0, 1,0,16'h0020,16'h0000, 1,0,16'h0030,16'h0000,16'h1111, 1, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000, 1,1);
      tv[16] = mk(0, 1,0,16'h0020,16'h0000, 1,0,16'h0030,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 1,16'h1111, 0,16'h0000, 0,0);
      tv[17] = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'h1111, 0,16'h0000, 0,0);
      tv[18] = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000,16'h0000, 1, 1,0,16'h0030,16'h0000, 0,16'h1111, 0,16'h0000, 0,1);
      tv[19] = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000,16'h2222, 1, 0,0,16'h0000,16'h0000, 0,16'h1111, 0,16'h0000, 0,1);
      tv[20] = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'h1111, 1,16'h2222, 0,0);
      tv[21] = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000,16'h0000, 1, 0,0,16'h0000,16'h0000, 0,16'h1111, 0,16'h2222, 0,0);

      for (int i = 0; i < NV; i++) begin
         @(negedge CLK);
         Reset = tv[i].rst;
         cpu_req = tv[i].creq; cpu_we = tv[i].cwe; cpu_addr = tv[i].caddr; cpu_wdata = tv[i].cwd;
         dbg_req = tv[i].dreq; dbg_we = tv[i].dwe; dbg_addr = tv[i].daddr; dbg_wdata = tv[i].dwd;
         mem_rdata = tv[i].mrd;
         #1;
         if (tv[i].chk) begin
            chk($sformatf("r%0d.mem_en", i),    en1,    tv[i].en);
            chk($sformatf("r%0d.mem_we", i),    we1,    tv[i].we);
            if (tv[i].en) chk($sformatf("r%0d.mem_addr", i), addr1, tv[i].addr);
            if (tv[i].we) chk($sformatf("r%0d.mem_wdata", i), wd1, tv[i].wd);
            chk($sformatf("r%0d.cpu_ack", i),   cack1,  tv[i].cack);
            chk($sformatf("r%0d.cpu_rdata", i), crd1,   tv[i].crd);
            chk($sformatf("r%0d.dbg_ack", i),   dack1,  tv[i].dack);
            chk($sformatf("r%0d.dbg_rdata", i), drd1,   tv[i].drd);
            chk($sformatf("r%0d.cpu_stall", i), stall1, tv[i].stall);
            chk($sformatf("r%0d.busy", i),      busy1,  tv[i].busy);
         end
      end

      // Continuous contention: grants must alternate CPU, DBG, ...
      @(negedge CLK); Reset = 1; drive_idle();
      @(negedge CLK); Reset = 0;
      cpu_req = 1; cpu_addr = 16'h0100; dbg_req = 1; dbg_addr = 16'h0200;
      mem_rdata = 16'hA5A5;
      begin
         int g;
         bit seen;
         g = 0;
         #1;
         for (int c = 0; c < 60 && g < 6; c++) begin
            if (en1) begin
               chk($sformatf("alt.grant%0d", g), addr1, (g % 2) ? 16'h0200 : 16'h0100);
               g++;
            end
            @(negedge CLK); #1;
         end
         if (g < 6) chk("alt.timeout", g, 6);
         seen = 0;
         for (int c = 0; c < 10 && !seen; c++) begin
            if (dack1) seen = 1;
            else begin @(negedge CLK); #1; end
         end
         if (!seen) chk("alt.last_ack", 0, 1);
      end
      @(negedge CLK); drive_idle();
      #1; chk("alt.cpu_rdata_hold", crd1, 16'hA5A5);

      // Reset in cycle 2 of a CPU read abandons it
      @(negedge CLK);
      cpu_req = 1; cpu_addr = 16'h0040; mem_rdata = 16'h5555;
      #1; chk("rst.c0_busy", busy1, 0);
      @(negedge CLK); #1;
      chk("rst.c1_en", en1, 1);
      chk("rst.c1_addr", addr1, 16'h0040);
      @(negedge CLK); Reset = 1;
      #1; chk("rst.c2_busy", busy1, 1);
      @(negedge CLK); Reset = 0; cpu_req = 0;
      #1;
      chk("rst.c3_en", en1, 0);
      chk("rst.c3_busy", busy1, 0);
      chk("rst.c3_rdata", crd1, 16'h0000);
      chk("rst.c3_ack", cack1, 0);
      for (int c = 4; c < 7; c++) begin
         @(negedge CLK); #1;
         chk($sformatf("rst.c%0d_ack", c), cack1, 0);
      end

      // MEM_LAT=3 CPU read
      @(negedge CLK); Reset = 1; drive_idle();
      @(negedge CLK); Reset = 0;
      cpu_req = 1; cpu_addr = 16'h0077; mem_rdata = 16'hBAD0;
      #1; chk("lat3.c0_busy", busy3, 0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         mem_rdata = (c == 4) ? 16'hC0DE : 16'hBAD0;
         cpu_req = (c <= 5);
         #1;
         chk($sformatf("lat3.c%0d_en", c), en3, (c == 1));
         chk($sformatf("lat3.c%0d_ack", c), cack3, (c == 5));
         chk($sformatf("lat3.c%0d_busy", c), busy3, (c >= 1 && c <= 4));
         if (c == 1) chk("lat3.c1_addr", addr3, 16'h0077);
         if (c == 5) chk("lat3.c5_rdata", crd3, 16'hC0DE);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
